// File: rtl/piece_ctrl_fsm_if.sv
// Command handshake and shape-lookup query bus between the piece controller
// (master) and the input/shape-lookup side (slave).
interface piece_ctrl_fsm_if #(
   parameter int BLK_BITS = 3,
   parameter int XW       = 4,
   parameter int YW       = 5,
   parameter int CW       = 8
);
   logic                cmd_valid;
   logic [2:0]          cmd_op;
   logic                cmd_ready;
   logic [BLK_BITS-1:0] q_blk;
   logic [XW-1:0]       q_pos_x;
   logic [YW-1:0]       q_pos_y;
   logic [1:0]          q_rot;
   logic [4*CW-1:0]     q_cells;
   logic [2:0]          q_width;
   logic [2:0]          q_height;

   modport master (
      input  cmd_valid, cmd_op, q_cells, q_width, q_height,
      output cmd_ready, q_blk, q_pos_x, q_pos_y, q_rot
   );

   modport slave (
      output cmd_valid, cmd_op, q_cells, q_width, q_height,
      input  cmd_ready, q_blk, q_pos_x, q_pos_y, q_rot
   );
endinterface

// File: rtl/piece_ctrl_fsm.sv
// Tetris active-piece controller: pose moves via a one-cycle shape query,
// locking into the stacked board, row clearing, spawning and game over.
//
// state    | meaning
// IDLE     | waiting for game_start
// SPAWN    | present new piece pose on the query bus
// SPCHK    | spawn pose collides -> GAMEOVER, else becomes the active pose
// ACTIVE   | accept fall ticks and player commands
// CHECK    | judge candidate pose; hard drop keeps stepping here
// LOCK     | requery the active pose
// MERGE    | write the active cells into the board
// CLEAR    | scan rows bottom-up, collapsing full rows
// GAMEOVER | stack reached the spawn area
module piece_ctrl_fsm #(
   parameter int BOARD_W  = 10,
   parameter int BOARD_H  = 20,
   parameter int BLK_BITS = 3,
   parameter int XW       = $clog2(BOARD_W),
   parameter int YW       = $clog2(BOARD_H),
   parameter int CW       = $clog2(BOARD_W*BOARD_H),
   parameter int LC_BITS  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       game_start,
   input  logic                       fall_tick,
   input  logic [BLK_BITS-1:0]        rnd_blk,
   piece_ctrl_fsm_if.master           bus,
   output logic [BLK_BITS-1:0]        blk,
   output logic [XW-1:0]              pos_x,
   output logic [YW-1:0]              pos_y,
   output logic [1:0]                 rot,
   output logic [BOARD_W*BOARD_H-1:0] board,
   output logic [LC_BITS-1:0]         lines_cleared,
   output logic                       game_over,
   output logic                       busy
);
   localparam int N         = BOARD_W*BOARD_H;
   localparam int SPAWN_X_I = BOARD_W/2 - 1;
   localparam int ROW_MAX_I = BOARD_H - 1;
   localparam logic [XW-1:0] SPAWN_X  = SPAWN_X_I[XW-1:0];
   localparam logic [YW-1:0] ROW_LAST = ROW_MAX_I[YW-1:0];
   localparam logic [XW:0]   W_LIM    = BOARD_W[XW:0];
   localparam logic [YW:0]   H_LIM    = BOARD_H[YW:0];

   typedef enum logic [3:0] {
      ST_IDLE, ST_SPAWN, ST_SPCHK, ST_ACTIVE, ST_CHECK,
      ST_LOCK, ST_MERGE, ST_CLEAR, ST_GAMEOVER
   } state_t;

   state_t              state_q, state_d;
   logic [BLK_BITS-1:0] blk_q, blk_d, q_blk_q, q_blk_d;
   logic [XW-1:0]       pos_x_q, pos_x_d, q_pos_x_q, q_pos_x_d;
   logic [YW-1:0]       pos_y_q, pos_y_d, q_pos_y_q, q_pos_y_d;
   logic [1:0]          rot_q, rot_d, q_rot_q, q_rot_d;
   logic [N-1:0]        board_q, board_d;
   logic [LC_BITS-1:0]  lc_q, lc_d;
   logic [YW-1:0]       row_q, row_d;
   logic                drop_q, drop_d, down_q, down_d;

   logic                cmd_ready_c;
   logic                hit, legal, row_full;
   logic [XW:0]         x_end, cand_x;
   logic [YW:0]         y_end, cand_y, act_y_inc, chk_y_inc;
   logic [1:0]          cand_rot;
   logic                mv_go, mv_down, mv_drop;
   logic [N-1:0]        shifted;

   // Query cells may point past the board for out-of-range candidates;
   // those never hit and are never written.
   function automatic logic cell_hit(input logic [4*CW-1:0] cells, input logic [N-1:0] brd);
      logic [CW-1:0] c;
      cell_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         c = cells[i*CW +: CW];
         if (int'(c) < N) cell_hit = cell_hit | brd[c];
      end
   endfunction

   function automatic logic [N-1:0] cell_mask(input logic [4*CW-1:0] cells);
      logic [CW-1:0] c;
      cell_mask = '0;
      for (int i = 0; i < 4; i++) begin
         c = cells[i*CW +: CW];
         if (int'(c) < N) cell_mask[c] = 1'b1;
      end
   endfunction

   always_comb begin
      hit       = cell_hit(bus.q_cells, board_q);
      x_end     = {1'b0, q_pos_x_q} + (XW+1)'(bus.q_width);
      y_end     = {1'b0, q_pos_y_q} + (YW+1)'(bus.q_height);
      legal     = (x_end <= W_LIM) && (y_end <= H_LIM) && !hit;
      act_y_inc = {1'b0, pos_y_q} + (YW+1)'(1);
      chk_y_inc = {1'b0, q_pos_y_q} + (YW+1)'(1);
      row_full  = &board_q[int'(row_q)*BOARD_W +: BOARD_W];

      shifted = board_q;
      shifted[BOARD_W-1:0] = '0;
      for (int r = 1; r < BOARD_H; r++) begin
         if (r <= int'(row_q)) shifted[r*BOARD_W +: BOARD_W] = board_q[(r-1)*BOARD_W +: BOARD_W];
      end
   end

   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      rot_d     = rot_q;
      q_blk_d   = q_blk_q;
      q_pos_x_d = q_pos_x_q;
      q_pos_y_d = q_pos_y_q;
      q_rot_d   = q_rot_q;
      board_d   = board_q;
      lc_d      = lc_q;
      row_d     = row_q;
      drop_d    = drop_q;
      down_d    = down_q;
      cmd_ready_c = 1'b0;
      mv_go     = 1'b0;
      mv_down   = 1'b0;
      mv_drop   = 1'b0;
      cand_x    = {1'b0, pos_x_q};
      cand_y    = {1'b0, pos_y_q};
      cand_rot  = rot_q;

      case (state_q)
         ST_IDLE, ST_GAMEOVER: begin
            if (game_start) begin
               board_d = '0;
               lc_d    = '0;
               state_d = ST_SPAWN;
            end
         end
         ST_SPAWN: begin
            q_blk_d   = rnd_blk;
            q_pos_x_d = SPAWN_X;
            q_pos_y_d = '0;
            q_rot_d   = '0;
            state_d   = ST_SPCHK;
         end
         ST_SPCHK: begin
            if (hit) begin
               state_d = ST_GAMEOVER;
            end else begin
               blk_d   = q_blk_q;
               pos_x_d = q_pos_x_q;
               pos_y_d = q_pos_y_q;
               rot_d   = q_rot_q;
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            cmd_ready_c = !fall_tick;
            // A command arriving with fall_tick is left pending, not consumed.
            if (fall_tick) begin
               mv_go   = 1'b1;
               mv_down = 1'b1;
               cand_y  = act_y_inc;
            end else if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  3'd0: begin
                     if (pos_x_q != '0) begin
                        mv_go  = 1'b1;
                        cand_x = {1'b0, pos_x_q - XW'(1)};
                     end
                  end
                  3'd1: begin
                     cand_x = {1'b0, pos_x_q} + (XW+1)'(1);
                     mv_go  = !cand_x[XW];
                  end
                  3'd2: begin
                     mv_go   = 1'b1;
                     mv_down = 1'b1;
                     cand_y  = act_y_inc;
                  end
                  3'd3: begin
                     mv_go    = 1'b1;
                     cand_rot = rot_q + 2'd1;
                  end
                  3'd4: begin
                     mv_go   = 1'b1;
                     mv_down = 1'b1;
                     mv_drop = 1'b1;
                     cand_y  = act_y_inc;
                  end
                  default: ;
               endcase
            end
            if (mv_go) begin
               q_blk_d   = blk_q;
               q_pos_x_d = cand_x[XW-1:0];
               q_pos_y_d = cand_y[YW-1:0];
               q_rot_d   = cand_rot;
               down_d    = mv_down;
               drop_d    = mv_drop;
               // y overflowing its field can only mean the floor was hit
               state_d   = cand_y[YW] ? ST_LOCK : ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (legal) begin
               pos_x_d = q_pos_x_q;
               pos_y_d = q_pos_y_q;
               rot_d   = q_rot_q;
               if (!drop_q)           state_d   = ST_ACTIVE;
               else if (chk_y_inc[YW]) state_d  = ST_LOCK;
               else                    q_pos_y_d = chk_y_inc[YW-1:0];
            end else begin
               state_d = down_q ? ST_LOCK : ST_ACTIVE;
            end
         end
         ST_LOCK: begin
            q_blk_d   = blk_q;
            q_pos_x_d = pos_x_q;
            q_pos_y_d = pos_y_q;
            q_rot_d   = rot_q;
            state_d   = ST_MERGE;
         end
         ST_MERGE: begin
            board_d = board_q | cell_mask(bus.q_cells);
            drop_d  = 1'b0;
            down_d  = 1'b0;
            row_d   = ROW_LAST;
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (row_full) begin
               board_d = shifted;
               if (lc_q != '1) lc_d = lc_q + LC_BITS'(1);
            end else if (row_q == '0) begin
               state_d = ST_SPAWN;
            end else begin
               row_d = row_q - YW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         blk_q     <= '0;
         pos_x_q   <= '0;
         pos_y_q   <= '0;
         rot_q     <= '0;
         q_blk_q   <= '0;
         q_pos_x_q <= '0;
         q_pos_y_q <= '0;
         q_rot_q   <= '0;
         board_q   <= '0;
         lc_q      <= '0;
         row_q     <= '0;
         drop_q    <= 1'b0;
         down_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         blk_q     <= blk_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         rot_q     <= rot_d;
         q_blk_q   <= q_blk_d;
         q_pos_x_q <= q_pos_x_d;
         q_pos_y_q <= q_pos_y_d;
         q_rot_q   <= q_rot_d;
         board_q   <= board_d;
         lc_q      <= lc_d;
         row_q     <= row_d;
         drop_q    <= drop_d;
         down_q    <= down_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_c;
   assign bus.q_blk     = q_blk_q;
   assign bus.q_pos_x   = q_pos_x_q;
   assign bus.q_pos_y   = q_pos_y_q;
   assign bus.q_rot     = q_rot_q;
   assign blk           = blk_q;
   assign pos_x         = pos_x_q;
   assign pos_y         = pos_y_q;
   assign rot           = rot_q;
   assign board         = board_q;
   assign lines_cleared = lc_q;
   assign game_over     = (state_q == ST_GAMEOVER);
   assign busy          = !((state_q == ST_ACTIVE) || (state_q == ST_IDLE) || (state_q == ST_GAMEOVER));
endmodule
